pitch_tracker: RTL and testbench
================================

# pitch_tracker

Downstream stage of the FFT peak finder in the pitch_detect pipeline. It takes one peak bin index, magnitude and valid pulse per FFT window and gates silent windows against a runtime threshold. It rejects single-window octave/jump glitches, smooths the accepted bin index with a moving average, and converts it to an integer frequency in Hz for the display/UI logic.

## Interface
- NSamples, 1024, FFT length; power of two.
- NBits, $clog2(NSamples), bin-index width.
- W, 33, magnitude width.
- FsHz, 48000, sample rate in Hz.
- FreqW, 16, output frequency width.
- AvgDepth, 4, moving-average depth; power of two, ≥2.
- JumpBins, 3, maximum bin distance still treated as "same pitch".
- SilenceFrames, 2, consecutive unvoiced windows before going silent; ≥1.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- peak, input, W, peak magnitude of the window.
- peak_k, input, NBits, peak bin index; MSB always 0.
- peak_valid, input, 1, one-cycle strobe; peak and peak_k are valid with it.
- threshold, input, W, voicing threshold; sampled with peak_valid.
- freq_hz, output, FreqW, smoothed frequency; 0 when silent.
- freq_valid, output, 1, one-cycle strobe, once per accepted peak_valid.
- voiced, output, 1, 1 while a pitch is being tracked.

## Operation
- A frame is voiced when peak ≥ threshold (unsigned).
- A frame is "near" x when |peak_k − x| ≤ JumpBins (unsigned difference, inclusive).
- ref is the bin index currently driving the output: the raw last-pushed k while fill < AvgDepth, otherwise sum >> log2(AvgDepth).
- History: AvgDepth-entry shift register of k, plus a running sum of NBits+log2(AvgDepth) bits and a fill count that saturates at AvgDepth.
- Push: sum += k_new − k_oldest. The oldest entry counts as 0 while not yet filled.
- Flush-load: clear the history, then store k (fill=1, sum=k).
- silence_cnt: increments on each unvoiced frame, saturates at SilenceFrames, and clears on any voiced frame.
- FSM states:
  - SILENT: voiced → flush-load k, go to TRACKING. Unvoiced → stay.
  - TRACKING: voiced and near ref → push k. Voiced and not near → cand_k ← k, go to CANDIDATE, no push.
  - CANDIDATE: voiced and near cand_k → flush-load k, go to TRACKING. Otherwise voiced and near ref → push k, go to TRACKING. Otherwise voiced → cand_k ← k, stay.
  - TRACKING or CANDIDATE, unvoiced: no push. When silence_cnt reaches SilenceFrames → clear history, go to SILENT.
- Frequency: freq_hz = (ref × FsHz) >> log2(NSamples), truncated. The product is NBits+$clog2(FsHz) bits. The result saturates to 2^FreqW−1 if it overflows.
- In SILENT, freq_hz = 0 and voiced = 0. In TRACKING/CANDIDATE, voiced = 1, and an unvoiced or rejected frame repeats the previous freq_hz.

## Timing
- Reset values: freq_hz=0, freq_valid=0, voiced=0. Internally: state=SILENT, history/sum/fill/silence_cnt/cand_k all 0, pipeline valids 0.
- Stage 1 (edge after peak_valid): FSM, history, sum, fill and ref are updated.
- Stage 2: multiply/shift/saturate; freq_hz, voiced and freq_valid are registered.
- Latency is exactly 2 cycles from peak_valid to freq_valid.
- freq_hz and voiced change only in the cycle freq_valid is high.
- peak_valid on consecutive cycles is fully supported. Each frame sees the state and ref left by the previous frame; no bubbles.
- Reset asserted in any cycle clears all in-flight frames: no freq_valid is produced for a frame sampled before reset. peak_valid during reset is ignored.

## Structure
- pitch_pkg holds:
  - the state enum (SILENT, TRACKING, CANDIDATE);
  - the default FsHz constant;
  - a shared function for the near-distance compare.
- One sub-module, k_history: shift register, running sum and fill count, with push/flush-load controls. It outputs the average and the last value. The FSM and frequency pipeline stay in pitch_tracker.

## Test plan
Defaults are used throughout; threshold = 1000.
- Reset, then one frame with peak=5000, k=21 → freq_valid exactly 2 cycles later, freq_hz=984, voiced=1. Before that frame, all outputs are 0.
- Frames k=20,20,21,21 (voiced) → freq_hz = 937, 937, 984, then 937 (sum 82 >> 2 = 20).
- From a full history at 20: k=40 → 937 (CANDIDATE). Then k=20 → 937 (TRACKING). Then k=40, k=41 → flush; output 1921.
- Tracking at 20: one frame with peak=500 → voiced=1, freq_hz=937. Second such frame → voiced=0, freq_hz=0. Then k=10 voiced → 468.
- peak_valid on 4 consecutive cycles with k=20,40,41,41 → four freq_valid pulses on consecutive cycles, values 937, 937, 1921, 1921.
- peak_valid at cycle t, reset at t+1 → no freq_valid at t+2, all outputs 0. The next frame with k=21 behaves as from SILENT (984).

Source files
------------

// File: rtl/pitch_pkg.sv
// Shared types and helpers for the pitch_tracker block: FSM states, default
// sample rate and the "same pitch" distance test.
package pitch_pkg;

    typedef enum logic [1:0] {
        SILENT    = 2'd0,
        TRACKING  = 2'd1,
        CANDIDATE = 2'd2
    } state_t;

    localparam int DefaultFsHz = 48000;

    // Inclusive unsigned distance test between two bin indices.
    function automatic logic is_near(input int unsigned a,
                                     input int unsigned b,
                                     input int unsigned jump);
        int unsigned diff;
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= jump);
    endfunction

endpackage

// File: rtl/pitch_tracker_if.sv
// Peak-in / frequency-out bundle between the FFT peak finder, pitch_tracker
// and the display logic.
interface pitch_tracker_if #(
    parameter int W     = 33,
    parameter int NBits = 10,
    parameter int FreqW = 16
);
    logic [W-1:0]     peak;
    logic [NBits-1:0] peak_k;
    logic             peak_valid;
    logic [W-1:0]     threshold;
    logic [FreqW-1:0] freq_hz;
    logic             freq_valid;
    logic             voiced;

    modport master (
        output peak, peak_k, peak_valid, threshold,
        input  freq_hz, freq_valid, voiced
    );

    modport slave (
        input  peak, peak_k, peak_valid, threshold,
        output freq_hz, freq_valid, voiced
    );
endinterface

// File: rtl/pitch_tracker_k_history.sv
// Bin-index history for pitch smoothing: shift register, running sum and a
// saturating fill count, with push / flush-load / clear controls.
module k_history #(
    parameter int NBits    = 10,
    parameter int AvgDepth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             flush_load,
    input  logic             clear,
    input  logic [NBits-1:0] k_in,
    output logic [NBits-1:0] avg,
    output logic [NBits-1:0] last,
    output logic             full
);
    localparam int LogD  = $clog2(AvgDepth);
    localparam int SumW  = NBits + LogD;
    localparam int FillW = $clog2(AvgDepth + 1);

    logic [NBits-1:0] hist [AvgDepth];
    logic [SumW-1:0]  sum;
    logic [FillW-1:0] fill;

    // Unfilled slots hold 0, so subtracting the oldest entry is always safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < AvgDepth; i++) hist[i] <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (flush_load) begin
            hist[0] <= k_in;
            for (int i = 1; i < AvgDepth; i++) hist[i] <= '0;
            sum  <= SumW'(k_in);
            fill <= FillW'(1);
        end else if (clear) begin
            for (int i = 0; i < AvgDepth; i++) hist[i] <= '0;
            sum  <= '0;
            fill <= '0;
        end else if (push) begin
            hist[0] <= k_in;
            for (int i = 1; i < AvgDepth; i++) hist[i] <= hist[i-1];
            sum <= sum + SumW'(k_in) - SumW'(hist[AvgDepth-1]);
            if (fill != FillW'(AvgDepth)) fill <= fill + FillW'(1);
        end
    end

    assign avg  = NBits'(sum >> LogD);
    assign last = hist[0];
    assign full = (fill == FillW'(AvgDepth));

endmodule

// File: rtl/pitch_tracker.sv
// Voicing gate, glitch-rejecting pitch tracker and bin-to-Hz conversion for
// one FFT peak per window; two-stage pipeline from peak_valid to freq_valid.
module pitch_tracker
    import pitch_pkg::*;
#(
    parameter int NSamples      = 1024,
    parameter int NBits         = $clog2(NSamples),
    parameter int W             = 33,
    parameter int FsHz          = DefaultFsHz,
    parameter int FreqW         = 16,
    parameter int AvgDepth      = 4,
    parameter int JumpBins      = 3,
    parameter int SilenceFrames = 2
) (
    input  logic clk,
    input  logic reset,
    pitch_tracker_if.slave bus
);
    localparam int LogN  = $clog2(NSamples);
    localparam int ProdW = NBits + $clog2(FsHz);
    localparam int SilW  = $clog2(SilenceFrames + 1);
    localparam logic [63:0] MaxFreq = (64'd1 << FreqW) - 64'd1;

    state_t           state, nxt_state;
    logic [NBits-1:0] cand_k, nxt_cand_k;
    logic [SilW-1:0]  silence_cnt, nxt_silence_cnt;
    logic             push, flush_load, clear_hist;
    logic             frame_voiced;
    logic [NBits-1:0] avg_k, last_k, ref_k;
    logic             hist_full;
    logic             s1_valid;
    logic [ProdW-1:0] prod;
    logic [FreqW-1:0] freq_calc;

    k_history #(
        .NBits    (NBits),
        .AvgDepth (AvgDepth)
    ) u_hist (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .flush_load (flush_load),
        .clear      (clear_hist),
        .k_in       (bus.peak_k),
        .avg        (avg_k),
        .last       (last_k),
        .full       (hist_full)
    );

    assign ref_k        = hist_full ? avg_k : last_k;
    assign frame_voiced = (bus.peak >= bus.threshold);

    always_comb begin
        nxt_state       = state;
        nxt_cand_k      = cand_k;
        push            = 1'b0;
        flush_load      = 1'b0;
        clear_hist      = 1'b0;
        if (frame_voiced)
            nxt_silence_cnt = '0;
        else if (silence_cnt == SilW'(SilenceFrames))
            nxt_silence_cnt = silence_cnt;
        else
            nxt_silence_cnt = silence_cnt + SilW'(1);

        if (bus.peak_valid) begin
            unique case (state)
                SILENT: begin
                    if (frame_voiced) begin
                        flush_load = 1'b1;
                        nxt_state  = TRACKING;
                    end
                end
                TRACKING, CANDIDATE: begin
                    if (frame_voiced) begin
                        if (state == CANDIDATE &&
                            is_near(32'(bus.peak_k), 32'(cand_k), JumpBins)) begin
                            flush_load = 1'b1;
                            nxt_state  = TRACKING;
                        end else if (is_near(32'(bus.peak_k), 32'(ref_k), JumpBins)) begin
                            push      = 1'b1;
                            nxt_state = TRACKING;
                        end else begin
                            nxt_cand_k = bus.peak_k;
                            nxt_state  = CANDIDATE;
                        end
                    end else if (nxt_silence_cnt >= SilW'(SilenceFrames)) begin
                        clear_hist = 1'b1;
                        nxt_state  = SILENT;
                    end
                end
                default: nxt_state = SILENT;
            endcase
        end
    end

    // Stage 1: tracker state; the history updates on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SILENT;
            cand_k      <= '0;
            silence_cnt <= '0;
            s1_valid    <= 1'b0;
        end else begin
            s1_valid <= bus.peak_valid;
            if (bus.peak_valid) begin
                state       <= nxt_state;
                cand_k      <= nxt_cand_k;
                silence_cnt <= nxt_silence_cnt;
            end
        end
    end

    always_comb begin
        prod      = ProdW'(ref_k) * ProdW'(FsHz);
        freq_calc = FreqW'(prod >> LogN);
        if (64'(prod >> LogN) > MaxFreq) freq_calc = '1;
    end

    // Stage 2: outputs only move when a frame completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.freq_hz    <= '0;
            bus.freq_valid <= 1'b0;
            bus.voiced     <= 1'b0;
        end else begin
            bus.freq_valid <= s1_valid;
            if (s1_valid) begin
                bus.voiced  <= (state != SILENT);
                bus.freq_hz <= (state == SILENT) ? '0 : freq_calc;
            end
        end
    end

endmodule

// File: tb/tb_pitch_tracker.sv
// Directed table-driven bench for pitch_tracker with hand-computed Hz values
// (bin * 48000 / 1024, truncated) plus multi-cycle pipeline/reset sequences.
module tb_pitch_tracker;
    localparam int W     = 33;
    localparam int NBits = 10;
    localparam int FreqW = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pitch_tracker_if #(.W(W), .NBits(NBits), .FreqW(FreqW)) bus ();

    pitch_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           rst_before;
        logic [W-1:0] peak;
        int           k;
        int           exp_freq;
        bit           exp_voiced;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.peak_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset freq_hz", int'(bus.freq_hz), 0);
        check("reset freq_valid", int'(bus.freq_valid), 0);
        check("reset voiced", int'(bus.voiced), 0);
    endtask

    task automatic run_frame(input string name, input logic [W-1:0] peak, input int k,
                             input int exp_freq, input bit exp_voiced);
        @(negedge clk);
        bus.peak = peak;
        bus.peak_k = NBits'(k);
        bus.peak_valid = 1'b1;
        @(negedge clk);
        bus.peak_valid = 1'b0;
        check({name, " early freq_valid"}, int'(bus.freq_valid), 0);
        @(negedge clk);
        check({name, " freq_valid"}, int'(bus.freq_valid), 1);
        check({name, " freq_hz"}, int'(bus.freq_hz), exp_freq);
        check({name, " voiced"}, int'(bus.voiced), int'(exp_voiced));
    endtask

    initial begin
        int exp_seq [4];
        int k_seq [4];
        reset = 1'b1;
        bus.peak = '0;
        bus.peak_k = '0;
        bus.peak_valid = 1'b0;
        bus.threshold = W'(1000);

        vecs.push_back('{1'b1, 33'd5000, 21, 984, 1'b1});
        vecs.push_back('{1'b1, 33'd5000, 20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 21, 984, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 21, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 40, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 40, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 41, 1921, 1'b1});
        vecs.push_back('{1'b1, 33'd5000, 20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd500,  20, 937, 1'b1});
        vecs.push_back('{1'b0, 33'd500,  20, 0,   1'b0});
        vecs.push_back('{1'b0, 33'd500,  20, 0,   1'b0});
        vecs.push_back('{1'b0, 33'd5000, 10, 468, 1'b1});
        vecs.push_back('{1'b0, 33'd500,  10, 468, 1'b1});
        vecs.push_back('{1'b0, 33'd1000, 10, 468, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 13, 609, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 17, 609, 1'b1});
        vecs.push_back('{1'b0, 33'd5000, 16, 750, 1'b1});
        vecs.push_back('{1'b0, 33'd999,  16, 750, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) do_reset();
            run_frame($sformatf("vec%0d", i), vecs[i].peak, vecs[i].k,
                      vecs[i].exp_freq, vecs[i].exp_voiced);
        end

        // Back-to-back frames: one result per cycle, each seeing the prior frame's state.
        do_reset();
        k_seq   = '{20, 40, 41, 41};
        exp_seq = '{937, 937, 1921, 1921};
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            if (j >= 2 && j < 6) begin
                check($sformatf("b2b%0d freq_valid", j - 2), int'(bus.freq_valid), 1);
                check($sformatf("b2b%0d freq_hz", j - 2), int'(bus.freq_hz), exp_seq[j-2]);
            end else begin
                check($sformatf("b2b idle%0d freq_valid", j), int'(bus.freq_valid), 0);
            end
            if (j < 4) begin
                bus.peak = W'(5000);
                bus.peak_k = NBits'(k_seq[j]);
                bus.peak_valid = 1'b1;
            end else begin
                bus.peak_valid = 1'b0;
            end
        end

        // Reset one cycle after a frame is sampled kills it in flight.
        do_reset();
        @(negedge clk);
        bus.peak = W'(5000);
        bus.peak_k = NBits'(40);
        bus.peak_valid = 1'b1;
        @(negedge clk);
        bus.peak_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort freq_valid", int'(bus.freq_valid), 0);
        check("abort freq_hz", int'(bus.freq_hz), 0);
        check("abort voiced", int'(bus.voiced), 0);
        @(negedge clk);
        check("abort late freq_valid", int'(bus.freq_valid), 0);
        run_frame("after abort", W'(5000), 21, 984, 1'b1);

        // A strobe while reset is held must leave no trace.
        @(negedge clk);
        reset = 1'b1;
        bus.peak_k = NBits'(30);
        bus.peak_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.peak_valid = 1'b0;
        @(negedge clk);
        check("held-reset freq_valid", int'(bus.freq_valid), 0);
        @(negedge clk);
        check("held-reset late freq_valid", int'(bus.freq_valid), 0);
        check("held-reset voiced", int'(bus.voiced), 0);
        run_frame("after held reset", W'(5000), 10, 468, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
